// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (mul, mulh, mulhu, div,
// divu, rem, remu). The unit runs a radix-2 shift-add multiply or a restoring
// divide on operand magnitudes. It applies sign fix-up and the special cases
// when it enters FIN, so every operation has the same latency.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request strobe, only looked at in IDLE
//   op     in   one-hot opcode [0]mul [1]mulh [2]mulhu [3]div [4]divu [5]rem [6]remu
//   src0   in   rs1 (multiplicand / dividend)
//   src1   in   rs2 (multiplier / divisor)
//   busy   out  high from the cycle after acceptance through the done cycle
//   done   out  one-cycle completion pulse
//   res    out  result, held until the next accepted start or reset
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [6:0]       op_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] dividend_q;
  logic             neg_res;
  logic             div_zero;
  logic             div_ovf;

  logic             op_valid;
  logic             signed_op;
  logic [WIDTH-1:0] abs0;
  logic [WIDTH-1:0] abs1;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   next_hi;
  logic [WIDTH-1:0]   next_lo;
  logic [2*WIDTH-1:0] neg_prod;
  logic [WIDTH-1:0]   final_res;

  // The request decode uses the raw inputs. For signed ops, operands are
  // converted to magnitudes here so the datapath is purely unsigned.
  always_comb begin
    op_valid  = (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
    signed_op = op[1] | op[3] | op[5];
    abs0      = (signed_op && src0[WIDTH-1]) ? -src0 : src0;
    abs1      = (signed_op && src1[WIDTH-1]) ? -src1 : src1;
  end

  // One iteration step for either algorithm. acc_hi/acc_lo hold the running
  // partial product (multiplier bits shift out of acc_lo) or the partial
  // remainder/quotient (dividend bits shift out of the top of acc_lo).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = div_shift >= {1'b0, opb};
    // The remainder after a successful subtract is below the divisor, so
    // the low WIDTH bits of the difference are exact.
    div_sub   = div_shift[WIDTH-1:0] - opb;
    if (|op_q[2:0]) begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      next_hi = div_ok ? div_sub : div_shift[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], div_ok};
    end
  end

  // This block produces the result from the final iteration's values. It
  // applies the sign fix-up and the forced special cases.
  always_comb begin
    neg_prod  = -{next_hi, next_lo};
    final_res = '0;
    unique case (1'b1)
      op_q[0]: final_res = next_lo;
      op_q[1]: final_res = neg_res ? neg_prod[2*WIDTH-1:WIDTH] : next_hi;
      op_q[2]: final_res = next_hi;
      op_q[3], op_q[4]: begin
        if (div_zero)     final_res = '1;
        else if (div_ovf) final_res = {1'b1, {(WIDTH-1){1'b0}}};
        else              final_res = neg_res ? -next_lo : next_lo;
      end
      op_q[5], op_q[6]: begin
        if (div_zero)     final_res = dividend_q;
        else if (div_ovf) final_res = '0;
        else              final_res = neg_res ? -next_hi : next_hi;
      end
      default: final_res = '0;
    endcase
  end

  // Control FSM with registered busy/done/res. Special cases are captured
  // at acceptance. The loop still runs its full length so latency is fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opb        <= '0;
      dividend_q <= '0;
      neg_res    <= 1'b0;
      div_zero   <= 1'b0;
      div_ovf    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && op_valid) begin
            state      <= CALC;
            busy       <= 1'b1;
            cnt        <= '0;
            op_q       <= op;
            acc_hi     <= '0;
            acc_lo     <= abs0;
            opb        <= abs1;
            dividend_q <= src0;
            neg_res    <= ((op[1] | op[3]) & (src0[WIDTH-1] ^ src1[WIDTH-1]))
                        | (op[5] & src0[WIDTH-1]);
            div_zero   <= (src1 == '0);
            div_ovf    <= (op[3] | op[5])
                        && (src0 == {1'b1, {(WIDTH-1){1'b0}}})
                        && (src1 == '1);
          end
        end
        CALC: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIN;
            done  <= 1'b1;
            res   <= final_res;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit for the RV32M subset the instruction decoder emits: mul, mulh, mulhu, div, divu, rem, remu.
- It consumes the decoder's M-extension one-hot opcode bits, the two register operands, and a start strobe.
- It returns the 32-bit result after a fixed multi-cycle latency and signals completion with a one-cycle done pulse.
- It sits beside the single-cycle ALU. Core control stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  7  one-hot opcode, equal to decoder alu_op[18:12]. Bit order: [0] mul, [1] mulh, [2] mulhu, [3] div, [4] divu, [5] rem, [6] remu.
- src0  input  WIDTH  rs1 operand (multiplicand/dividend).
- src1  input  WIDTH  rs2 operand (multiplier/divisor).
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse; res is valid in this cycle.
- res  output  WIDTH  result; holds its value until the next accepted start or reset.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state=IDLE; busy=0, done=0, res=0; all internal accumulators cleared.
  - Reset mid-operation aborts the computation; no done pulse is produced for it.
- Acceptance rules:
  - A request is accepted at the rising edge where state=IDLE, start=1 and op is exactly one-hot.
  - op=0 or multi-hot: start is ignored, state stays IDLE, no done.
  - start while busy is ignored; operands and op are not re-sampled.
  - On acceptance, op, src0 and src1 are latched; inputs may change afterwards without effect.
- States:
  - IDLE: wait for an accepted start.
  - CALC: WIDTH cycles with an iteration counter counting 0..WIDTH-1.
  - FIN: one cycle; done=1, busy=1, res driven.
  - Transitions: IDLE->CALC on accept; CALC->FIN when the counter reaches WIDTH-1; FIN->IDLE unconditionally.
  - A start in the FIN cycle is ignored. The earliest back-to-back start is the first IDLE cycle after FIN.
- Latency:
  - Accept at edge of cycle 0. busy=1 in cycles 1..WIDTH+1. done=1 in cycle WIDTH+1 (33 for the default).
  - Latency is fixed for all ops and special cases.
- Multiply (radix-2 shift-add on magnitudes, 2*WIDTH-bit product):
  - mul: low WIDTH bits of the product; identical for signed and unsigned operands.
  - mulh: both operands are treated as signed. Multiply the magnitudes, then negate the 64-bit product if the operand signs differ; res = high WIDTH bits.
  - mulhu: both operands unsigned; res = high WIDTH bits.
- Divide (radix-2 restoring on magnitudes):
  - Signed ops (div, rem): divide the magnitudes.
    - Quotient is negated iff the operand signs differ.
    - Remainder takes the sign of the dividend.
    - Quotient truncates toward zero.
  - Divide by zero (src1=0):
    - div and divu give all-ones (div = -1; divu = 0xFFFFFFFF).
    - rem and remu give src0.
  - Signed overflow (src0=0x80000000, src1=0xFFFFFFFF): div gives 0x80000000; rem gives 0.
  - Special cases are detected at acceptance and forced in FIN; the iteration still runs its full length so latency stays fixed.
- Output timing:
  - done is never high for two consecutive cycles.
  - res changes only at the FIN entry edge or on reset.
  - busy=0 exactly when state=IDLE.

Test Plan:
- Reset mid-CALC: start mul 3×5, assert rst at cycle 10 -> busy=0, done=0, res=0 the next cycle; no done pulse appears within the following 40 cycles.
- Basic multiplies:
  - mul 0x00000007×0xFFFFFFFD -> res=0xFFFFFFEB, done exactly at cycle 33.
  - mulh 0x80000000×0x80000000 -> res=0x40000000.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF -> res=0xFFFFFFFE.
- Signed divide:
  - div -7/2 -> 0xFFFFFFFD.
  - rem -7/2 -> 0xFFFFFFFF.
  - divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
  - remu 0xFFFFFFF9/2 -> 1.
- Special cases:
  - div 5/0 -> 0xFFFFFFFF.
  - rem 5/0 -> 5.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000.
  - rem same operands -> 0.
  - Each completes at cycle 33.
- Handshake:
  - start with op=0 -> no busy.
  - start with op=0b0001001 -> no busy.
  - Second start during CALC with different operands -> ignored; the first result is returned.
  - Operands changed after acceptance -> the result is unaffected.
- Back-to-back: start remu 100/7 immediately after FIN -> done 33 cycles later with res=2; res holds the previous value between the two operations.
